// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage in-order pipeline: load-use / RAW stall detection,
// branch flush and EX operand forwarding, all driven from shadow copies of ID/EX, EX/MEM, MEM/WB.
module pipe_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter bit FWD_EN = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              branch_taken,
   output logic              stall,
   output logic              flush_ifid,
   output logic              bubble_idex,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cycles
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              use_rs;
      logic              use_rt;
      logic [REG_AW-1:0] dest;
      logic              reg_write;
      logic              mem_read;
   } rec_t;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   rec_t idex, exmem, memwb, id_rec;
   logic stall_raw;

   // Register 0 is hard-wired, so a write to it can never create a dependency.
   function automatic logic is_src(rec_t r);
      return r.valid & r.reg_write & (r.dest != '0);
   endfunction

   function automatic logic id_match(rec_t r, logic valid, logic use_rs, logic use_rt,
                                     logic [REG_AW-1:0] rs, logic [REG_AW-1:0] rt);
      return valid & is_src(r) & ((use_rs & (rs == r.dest)) | (use_rt & (rt == r.dest)));
   endfunction

   // The younger producer (EX/MEM) wins; a load in EX/MEM has no data yet, so it never forwards.
   function automatic logic [1:0] fwd_sel(rec_t ex_rec, logic use_src, logic [REG_AW-1:0] src,
                                          rec_t em, rec_t mw);
      logic [1:0] sel;
      sel = FWD_RF;
      if (ex_rec.valid && use_src) begin
         if (is_src(em) && (em.dest == src) && !em.mem_read)
            sel = FWD_EXMEM;
         else if (is_src(mw) && (mw.dest == src))
            sel = FWD_MEMWB;
      end
      return sel;
   endfunction

   assign id_rec = '{valid: 1'b1, rs: id_rs, rt: id_rt, use_rs: id_use_rs, use_rt: id_use_rt,
                     dest: id_dest, reg_write: id_reg_write, mem_read: id_mem_read};

   always_comb begin
      stall_raw = 1'b0;
      fwd_a     = FWD_RF;
      fwd_b     = FWD_RF;
      if (FWD_EN) begin
         stall_raw = id_match(idex, id_valid, id_use_rs, id_use_rt, id_rs, id_rt) & idex.mem_read;
         fwd_a     = fwd_sel(idex, idex.use_rs, idex.rs, exmem, memwb);
         fwd_b     = fwd_sel(idex, idex.use_rt, idex.rt, exmem, memwb);
      end else begin
         // Write-before-read regfile: only producers still in EX or MEM must be waited on.
         stall_raw = id_match(idex, id_valid, id_use_rs, id_use_rt, id_rs, id_rt)
                   | id_match(exmem, id_valid, id_use_rs, id_use_rt, id_rs, id_rt);
      end
   end

   // A taken branch squashes the ID instruction, so its hazard is moot.
   assign stall       = stall_raw & ~branch_taken;
   assign flush_ifid  = branch_taken;
   assign bubble_idex = stall | branch_taken;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idex         <= '0;
         exmem        <= '0;
         memwb        <= '0;
         stall_cycles <= '0;
      end else begin
         memwb <= exmem;
         exmem <= idex;
         if (stall || branch_taken || !id_valid)
            idex <= '0;
         else
            idex <= id_rec;
         if (stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-address width.
REQ-002 SHALL have parameter FWD_EN, default 1: 1 = forwarding mode; 0 = stall-only mode.
REQ-003 SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-004 SHALL have port clock, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports id_rs and id_rt, input, REG_AW each: source registers of the instruction in ID.
REQ-007 SHALL have ports id_use_rs and id_use_rt, input, 1 each: the ID instruction reads rs / rt.
REQ-008 SHALL have port id_valid, input, 1: the ID slot holds a real instruction.
REQ-009 SHALL have port id_dest, input, REG_AW: destination register of the ID instruction.
REQ-010 SHALL have ports id_reg_write and id_mem_read, input, 1 each: decoded write-back and load flags.
REQ-011 SHALL have port branch_taken, input, 1: branch resolved taken in EX this cycle.
REQ-012 SHALL have port stall, output, 1: hold PC and IF/ID.
REQ-013 SHALL have port flush_ifid, output, 1: clear IF/ID.
REQ-014 SHALL have port bubble_idex, output, 1: load a NOP into ID/EX.
REQ-015 SHALL have ports fwd_a and fwd_b, output, 2 each: EX operand source; 00 = regfile, 10 = EX/MEM, 01 = MEM/WB.
REQ-016 SHALL have port stall_cycles, output, CNT_W: saturating count of stall cycles.

Function
REQ-017 SHALL keep three internal shadow records: idex, exmem, memwb. Each record holds {valid, rs, rt, use_rs, use_rt, dest, reg_write, mem_read}.
REQ-018 SHALL advance the records every cycle: memwb<=exmem, exmem<=idex.
REQ-019 SHALL load idex as follows: if stall, branch_taken or !id_valid, idex<=invalid (all fields 0); otherwise idex<=the ID inputs.
REQ-020 SHALL treat a record as a hazard source only if valid=1, reg_write=1 and dest!=0. Register 0 never causes a stall or a forward.
REQ-021 SHALL compute "ID source matches record X" as: (id_use_rs & id_rs==X.dest) | (id_use_rt & id_rt==X.dest), with X a hazard source and id_valid=1.
REQ-022 SHALL, when FWD_EN=1, assert stall combinationally only when the ID source matches idex and idex.mem_read=1 (load-use, exactly 1 bubble).
REQ-023 SHALL, when FWD_EN=0, assert stall when the ID source matches idex or exmem. The regfile is write-before-read, so memwb never stalls.
REQ-024 SHALL, when FWD_EN=1, derive fwd_a from idex.rs: 10 if exmem is a hazard source with exmem.dest==idex.rs and exmem.mem_read=0; else 01 if memwb is a hazard source with memwb.dest==idex.rs; else 00. fwd_a SHALL be 00 if idex is invalid or idex.use_rs=0.
REQ-025 SHALL derive fwd_b identically using rt and use_rt.
REQ-026 SHALL, when FWD_EN=0, hold fwd_a and fwd_b at 00 permanently.
REQ-027 SHALL give exmem priority over memwb when both match (youngest wins).
REQ-028 SHALL, when branch_taken=1, assert flush_ifid=1 and bubble_idex=1 in the same cycle, and force stall=0. Branch priority beats load-use.
REQ-029 SHALL set bubble_idex = stall | branch_taken.
REQ-030 SHALL make all outputs except stall_cycles purely combinational from the inputs and the records, with zero latency.
REQ-031 SHALL increment stall_cycles by 1 on each rising edge where stall=1, and saturate at 2^CNT_W-1 with no wrap.

Reset
REQ-032 SHALL, while reset=0, asynchronously clear all records to invalid and stall_cycles to 0. Hence stall=0, flush_ifid=0, bubble_idex=0 and fwd_a=fwd_b=00 unless branch_taken=1.
REQ-033 SHALL, on reset asserted mid-stall, discard the pending hazard; the first cycle after release evaluates only the new ID inputs.
REQ-034 SHALL resume normal updates on the first rising edge after reset returns to 1.

Verification
REQ-035 SHALL test the back-to-back ALU case, FWD_EN=1: add $3 then sub uses $3 -> stall never asserted; fwd_a=10 in sub's EX cycle.
REQ-036 SHALL test load-use, FWD_EN=1: lw $5 then add reads $5 -> stall=1 for exactly 1 cycle, stall_cycles 0->1; next EX cycle fwd=01.
REQ-037 SHALL test the double match: add $4, add $4, then use $4 -> fwd=10 (exmem wins over memwb).
REQ-038 SHALL test FWD_EN=0 with add $2 then use $2 -> stall=1 for 2 cycles; fwd held at 00; stall_cycles=2.
REQ-039 SHALL test a load-use hazard present together with branch_taken=1 -> stall=0, flush_ifid=1, bubble_idex=1, stall_cycles unchanged.
REQ-040 SHALL test writes to $0, and reset pulsed low during a stall -> writing $0 never stalls or forwards; after the reset pulse stall_cycles=0 and all records are invalid.
